// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: round-robin arbitration between CPU and debug
// load/store requests, split into one byte-wide big-endian array access per cycle.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_BITS = 8,
    parameter bit          RR_RESET  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [5:0]           cpu_opcode,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_done,
    output logic                 cpu_err,
    output logic [31:0]          cpu_rdata,
    input  logic                 dbg_req,
    input  logic [5:0]           dbg_opcode,
    input  logic [31:0]          dbg_addr,
    input  logic [31:0]          dbg_wdata,
    output logic                 dbg_done,
    output logic                 dbg_err,
    output logic [31:0]          dbg_rdata,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 6;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   rr_q, rr_d;
    logic                   owner_q, owner_d;
    logic [3:0]             op_q, op_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [DATA_W-1:0]      asm_q, asm_d;

    logic                   cpu_done_q, cpu_done_d, cpu_err_q, cpu_err_d;
    logic                   dbg_done_q, dbg_done_d, dbg_err_q, dbg_err_d;
    logic [DATA_W-1:0]      cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic                   mem_we_q, mem_we_d;
    logic [7:0]             mem_wdata_q, mem_wdata_d;

    logic                   gnt_dbg, err_d, done_d, misaligned;
    logic [OP_W-1:0]        sel_op;
    logic [DATA_W-1:0]      sel_addr, sel_wdata, rdata_d;
    logic [1:0]             byte_idx;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
            6'b101000, 6'b101001, 6'b101011: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // op[3] = store, op[2] = unsigned, op[1:0] = last byte index (0, 1 or 3)
    function automatic logic [DATA_W-1:0] load_ext(input logic [3:0] op, input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = a;
        if (op[3])
            r = '0;
        else if (op[1:0] == 2'b00)
            r = op[2] ? {24'h0, a[7:0]} : {{24{a[7]}}, a[7:0]};
        else if (op[1:0] == 2'b01)
            r = op[2] ? {16'h0, a[15:0]} : {{16{a[15]}}, a[15:0]};
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        err_d      = 1'b0;
        gnt_dbg    = 1'b0;
        misaligned = 1'b0;
        sel_op     = cpu_opcode;
        sel_addr   = cpu_addr;
        sel_wdata  = cpu_wdata;

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    gnt_dbg = dbg_req && (!cpu_req || rr_q);
                    if (cpu_req && dbg_req)
                        rr_d = !gnt_dbg;
                    if (gnt_dbg) begin
                        sel_op    = dbg_opcode;
                        sel_addr  = dbg_addr;
                        sel_wdata = dbg_wdata;
                    end
                    misaligned = (sel_op[1:0] == 2'b01 && sel_addr[0]) ||
                                 (sel_op[1:0] == 2'b11 && sel_addr[1:0] != 2'b00);
                    owner_d = gnt_dbg;
                    op_d    = sel_op[3:0];
                    addr_d  = sel_addr[ADDR_BITS-1:0];
                    wdata_d = sel_wdata;
                    cnt_d   = 2'b00;
                    asm_d   = '0;
                    if (!op_legal(sel_op) || (sel_addr >> ADDR_BITS) != '0 || misaligned) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!op_q[3])
                    asm_d = {asm_q[DATA_W-9:0], mem_rdata};
                cnt_d = cnt_q + 2'b01;
                if (cnt_q == op_q[1:0])
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Output registers are loaded with the values for the cycle being entered
        done_d      = (state_d == DONE);
        rdata_d     = (done_d && !err_d) ? load_ext(op_d, asm_d) : '0;
        cpu_done_d  = done_d && !owner_d;
        cpu_err_d   = err_d && !owner_d;
        cpu_rdata_d = owner_d ? '0 : rdata_d;
        dbg_done_d  = done_d && owner_d;
        dbg_err_d   = err_d && owner_d;
        dbg_rdata_d = owner_d ? rdata_d : '0;

        byte_idx    = op_d[1:0] - cnt_d;
        mem_we_d    = (state_d == ACCESS) && op_d[3];
        mem_addr_d  = (state_d == ACCESS) ? addr_d + ADDR_BITS'(cnt_d) : '0;
        mem_wdata_d = mem_we_d ? 8'(wdata_d >> {byte_idx, 3'b000}) : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= RR_RESET;
            owner_q     <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
            cpu_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_done_q  <= 1'b0;
            dbg_err_q   <= 1'b0;
            dbg_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            cpu_done_q  <= cpu_done_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_done_q  <= dbg_done_d;
            dbg_err_q   <= dbg_err_d;
            dbg_rdata_q <= dbg_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_done  = cpu_done_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_done  = dbg_done_q;
    assign dbg_err   = dbg_err_q;
    assign dbg_rdata = dbg_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences CPU and debug-port load/store requests onto the single byte-wide data memory array (256 x 8, big-endian, byte-addressed).
- Shares that array between the two requesters with round-robin arbitration.
- Breaks each sb/sh/sw/lb/lh/lw/lbu/lhu into one byte access per cycle, then assembles the load result and sign- or zero-extends it.
- Sits between the MEM stage / debug unit and the memory array.

Parameters:
- ADDR_BITS, 8, byte-address width of the memory array; addresses at or above 2^ADDR_BITS are rejected.
- RR_RESET, 0, requester that holds round-robin priority after reset (0 = CPU, 1 = debug).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU request; held high until cpu_done.
- cpu_opcode  input  6  MIPS opcode: 100000 lb, 100001 lh, 100011 lw, 100100 lbu, 100101 lhu, 101000 sb, 101001 sh, 101011 sw.
- cpu_addr  input  32  byte address (ALU result).
- cpu_wdata  input  32  store data (rt register).
- cpu_done  output  1  one-cycle completion pulse.
- cpu_err  output  1  valid with cpu_done: misaligned, out-of-range or illegal opcode.
- cpu_rdata  output  32  load result; valid with cpu_done.
- dbg_req, dbg_opcode, dbg_addr, dbg_wdata, dbg_done, dbg_err, dbg_rdata: debug-port copies of the CPU ports, same widths and meanings.
- mem_addr  output  ADDR_BITS  array byte address.
- mem_we  output  1  array write enable; the array writes on posedge when high.
- mem_wdata  output  8  array write byte.
- mem_rdata  input  8  array read byte, combinational from mem_addr.

Behaviour:
- Reset (async): FSM to IDLE; all outputs 0; byte counter 0; assembly register 0; priority = RR_RESET. Reset during an access aborts it: mem_we drops immediately, no done pulse, partial stores are not rolled back.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Arbitrate among the requests that are high. If only one is high, it wins. If both are high, the requester holding priority wins, and priority then passes to the other.
  - Latch the winner's opcode, addr and wdata. Later changes on the requester's inputs are ignored.
  - Error check: opcode not in the list, addr[31:ADDR_BITS] nonzero, halfword with addr[0]=1, or word with addr[1:0] nonzero. On error go to DONE with err=1 and make no memory access.
  - Otherwise set N (1, 2 or 4 bytes), counter = 0, go to ACCESS.
- ACCESS:
  - mem_addr = latched addr + counter, modulo 2^ADDR_BITS.
  - Store: mem_we = 1; mem_wdata = byte (N-1-counter) of wdata, MSB first (sh writes wdata[15:8] then wdata[7:0]; sw writes [31:24] first).
  - Load: mem_we = 0; shift mem_rdata into the assembly register, MSB first.
  - Counter increments each cycle. After byte N-1, go to DONE.
- DONE:
  - Pulse the winner's done for exactly one cycle, with err and rdata valid in that cycle.
  - rdata: lb/lh sign-extend, lbu/lhu zero-extend, lw as assembled; stores return 0.
  - Return to IDLE.
- Latency from req sampled high in IDLE to done: 2 + N cycles on success (sw = 6, sb = 3); 2 cycles on error.
- mem_we is high only in ACCESS for a store. Non-winning done/err/rdata stay 0.
- A requester that drops req mid-access does not cancel it; the done pulse is still issued.
- After DONE the FSM spends one IDLE cycle before the next grant, so back-to-back requests never overlap.

Test Plan:
- Word round trip: CPU sw addr=0x10 wdata=0xDEADBEEF -> writes mem[0x10..0x13] = DE,AD,BE,EF on 4 consecutive cycles; cpu_done 6 cycles after req. Then CPU lw 0x10 -> cpu_rdata = 0xDEADBEEF, cpu_err = 0.
- Extension: mem[0x20] = 0x80. lb 0x20 -> 0xFFFFFF80; lbu 0x20 -> 0x00000080. sh 0x22 data 0x00001234, then lh 0x22 -> 0x00001234.
- Errors: lw 0x11 -> cpu_err = 1 after 2 cycles, mem_we never high. sh 0x101 -> err (out of range). opcode 000000 -> err.
- Arbitration: cpu_req and dbg_req both high from reset with RR_RESET=0 -> CPU served first, debug served next. Hold both high for 4 transactions -> grants alternate C,D,C,D.
- Reset mid-store: assert reset during the 2nd byte of sw 0x40 -> mem_we drops asynchronously, no done pulse, FSM in IDLE. A following lw 0x40 returns byte 0 new, bytes 1-3 old.
- Request withdrawal: dbg_req drops during ACCESS -> access completes and dbg_done pulses once; cpu_rdata stays 0 throughout.
